led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised successor to the free-running LED counter on the iCE40 boards.
- Drives N_LEDS outputs from a programmable prescaler in one of four modes: binary count, bouncing chase, PWM breathing, or static pattern.
- Sits directly behind the global-buffered board clock as the board-bring-up and status indicator block.
- All outputs are registered.

Parameters:
- N_LEDS, 5, number of LED outputs (>=1).
- PRESCALE, 2097152, clock cycles per step tick (>=2).
- PWM_W, 8, width of the breathing PWM counter and duty register.

Ports:
- clki  in  1  board clock (post global buffer); all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes all state and outputs.
- mode  in  2  0=binary, 1=chase, 2=breathe, 3=static.
- static_pat  in  N_LEDS  pattern shown in mode 3.
- leds  out  N_LEDS  LED drive, registered, active-high.
- tick  out  1  one-cycle pulse on each prescaler terminal count.

Behaviour:
- Reset (rst high at a clki edge): leds=0, tick=0, prescaler=0, step=0, pos=0, dir=up, duty=0, duty_dir=up, pwm_cnt=0, mode_q=0. rst has priority over everything else.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1, then wraps to 0.
  - tick register is set in the cycle the count is PRESCALE-1 with en=1, so tick is high for exactly one cycle per PRESCALE enabled cycles.
  - Internal step events use the same terminal condition.
- en=0: prescaler, pwm_cnt, step, pos, duty and leds all hold; tick=0.
- Mode tracking:
  - mode_q registers mode every enabled cycle.
  - When mode != mode_q, that cycle clears prescaler, step, pos, duty and pwm_cnt, and sets dir/duty_dir=up. No step occurs that cycle.
  - The new mode's output appears in leds the following cycle.
  - A mode change while en=0 is acted on at the first enabled cycle.
- Mode 0, binary:
  - step is N_LEDS wide, +1 per tick, wraps from all-ones to 0.
  - leds = step.
- Mode 1, chase:
  - leds = one-hot at bit pos. Bounce sequence 0,1,..,N-1,N-2,..,1,0,1,...
  - At a tick with dir=up and pos=N_LEDS-1: dir=down, pos=N_LEDS-2.
  - At a tick with dir=down and pos=0: dir=up, pos=1.
  - Otherwise pos moves ±1.
  - N_LEDS=1: pos stays 0 and leds=1.
- Mode 2, breathe:
  - pwm_cnt (PWM_W bits) increments every enabled cycle and wraps.
  - duty moves ±1 per tick, between 0 and 2^PWM_W-1.
  - Reversal: at max with duty_dir=up, the next tick sets duty_dir=down and duty=max-1. At 0 with duty_dir=down, the next tick sets duty_dir=up and duty=1.
  - All leds bits = (pwm_cnt < duty). duty=0 gives fully off; duty=max gives on for max of every 2^PWM_W cycles.
- Mode 3, static:
  - leds = static_pat, sampled every enabled cycle, so one-cycle latency.
  - Step state is not advanced.
- Latency:
  - Step state changes at the clki edge where the terminal count is reached.
  - leds reflects the new state one cycle later (leds is registered from state).
  - tick and the state change share the same edge.
- Reset mid-operation: next cycle shows reset values regardless of mode or en. Counting resumes from 0.

Test Plan (PRESCALE=4, N_LEDS=5, PWM_W=3 unless stated):
1. rst high 3 cycles with en=1, mode=0 -> leds=0, tick=0. After release: tick high on cycles 4, 8, 12 after reset; leds = 1, 2, 3 one cycle after each tick. Run 32 ticks -> leds wraps 31->0.
2. mode=1, en=1 -> leds sequence over ticks: 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010. Repeat with N_LEDS=1 -> leds stays 1.
3. mode=2 -> duty ramps 0..7..0 over 14 ticks. At duty=3, leds high for exactly 3 of every 8 cycles. At duty=0, leds never high. At duty=7, high 7 of every 8.
4. Binary mode, leds=5; drop en for 10 cycles -> leds, tick and prescaler frozen. Raise en -> next tick arrives after the remaining prescaler count, not 4 cycles.
5. Switch mode 0->3 with static_pat=10101 mid-prescale -> leds=10101 within 2 cycles. Switch 3->1 -> leds=00001, first step exactly 4 cycles after the change.
6. Assert rst for 1 cycle while in mode 2 with duty=5 -> leds=0 and duty=0 next cycle. A following mode change with en=0 has no effect until en=1.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle: run controls in, LED drive and tick out.
interface led_pattern_gen_if #(
  parameter int N_LEDS = 5
);
  logic              en;
  logic [1:0]        mode;
  logic [N_LEDS-1:0] static_pat;
  logic [N_LEDS-1:0] leds;
  logic              tick;

  modport master (output en, mode, static_pat, input leds, tick);
  modport slave  (input en, mode, static_pat, output leds, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// Board status LED driver: prescaled step ticks feeding binary, bounce-chase,
// PWM breathing or static patterns. All outputs registered.
module led_pattern_gen #(
  parameter int N_LEDS   = 5,
  parameter int PRESCALE = 2097152,
  parameter int PWM_W    = 8
) (
  input  logic           clki,
  input  logic           rst,
  led_pattern_gen_if.slave bus
);
  localparam int PSW  = $clog2(PRESCALE);
  localparam int POSW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PSW-1:0]   PS_LAST  = PSW'(PRESCALE - 1);
  localparam logic [POSW-1:0]  POS_LAST = POSW'(N_LEDS - 1);
  localparam logic [POSW-1:0]  POS_TURN = POSW'((N_LEDS > 1) ? N_LEDS - 2 : 0);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
  typedef enum logic [1:0] {M_BIN, M_CHASE, M_BREATHE, M_STATIC} mode_t;

  logic [PSW-1:0]    presc,    presc_n;
  logic [N_LEDS-1:0] step,     step_n;
  logic [POSW-1:0]   pos,      pos_n;
  dir_t              dir,      dir_n;
  logic [PWM_W-1:0]  duty,     duty_n;
  dir_t              duty_dir, duty_dir_n;
  logic [PWM_W-1:0]  pwm_cnt,  pwm_cnt_n;
  mode_t             mode_q,   mode_n;
  logic [N_LEDS-1:0] leds_q,   leds_n;
  logic              tick_q,   tick_n;
  logic              term;

  assign term = (presc == PS_LAST);

  always_comb begin
    presc_n    = presc;
    step_n     = step;
    pos_n      = pos;
    dir_n      = dir;
    duty_n     = duty;
    duty_dir_n = duty_dir;
    pwm_cnt_n  = pwm_cnt;
    mode_n     = mode_q;
    leds_n     = leds_q;
    tick_n     = 1'b0;
    if (bus.en) begin
      mode_n = mode_t'(bus.mode);
      // leds always follow the registered mode/state, hence the one-cycle lag
      unique case (mode_q)
        M_BIN:     leds_n = step;
        M_CHASE:   leds_n = N_LEDS'(1) << pos;
        M_BREATHE: leds_n = {N_LEDS{pwm_cnt < duty}};
        default:   leds_n = bus.static_pat;
      endcase
      if (mode_t'(bus.mode) != mode_q) begin
        presc_n    = '0;
        step_n     = '0;
        pos_n      = '0;
        dir_n      = UP;
        duty_n     = '0;
        duty_dir_n = UP;
        pwm_cnt_n  = '0;
      end else begin
        presc_n   = term ? '0 : presc + 1'b1;
        pwm_cnt_n = pwm_cnt + 1'b1;
        tick_n    = term;
        if (term) begin
          unique case (mode_q)
            M_BIN: step_n = step + 1'b1;
            M_CHASE: begin
              if (N_LEDS > 1) begin
                if (dir == UP) begin
                  if (pos == POS_LAST) begin
                    dir_n = DOWN;
                    pos_n = POS_TURN;
                  end else begin
                    pos_n = pos + 1'b1;
                  end
                end else if (pos == '0) begin
                  dir_n = UP;
                  pos_n = POSW'(1);
                end else begin
                  pos_n = pos - 1'b1;
                end
              end
            end
            M_BREATHE: begin
              if (duty_dir == UP) begin
                if (duty == DUTY_MAX) begin
                  duty_dir_n = DOWN;
                  duty_n     = DUTY_MAX - 1'b1;
                end else begin
                  duty_n = duty + 1'b1;
                end
              end else if (duty == '0) begin
                duty_dir_n = UP;
                duty_n     = PWM_W'(1);
              end else begin
                duty_n = duty - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      presc    <= '0;
      step     <= '0;
      pos      <= '0;
      dir      <= UP;
      duty     <= '0;
      duty_dir <= UP;
      pwm_cnt  <= '0;
      mode_q   <= M_BIN;
      leds_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      presc    <= presc_n;
      step     <= step_n;
      pos      <= pos_n;
      dir      <= dir_n;
      duty     <= duty_n;
      duty_dir <= duty_dir_n;
      pwm_cnt  <= pwm_cnt_n;
      mode_q   <= mode_n;
      leds_q   <= leds_n;
      tick_q   <= tick_n;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;
endmodule
